// File: rtl/seq_comparator_param.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the MSB end and
// stops at the first slice that differs, reporting lt/eq/gt for signed or unsigned operands.
module seq_comparator_param #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NSLICE - 1);
  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("seq_comparator_param: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sign_q;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;

  // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
  always_comb begin
    slice_a = op_a[int'(idx) * CHUNK +: CHUNK];
    slice_b = op_b[int'(idx) * CHUNK +: CHUNK];
    if (sign_q && (idx == TOP_IDX)) begin
      slice_a = slice_a ^ MSB_MASK;
      slice_b = slice_b ^ MSB_MASK;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= TOP_IDX;
      op_a   <= '0;
      op_b   <= '0;
      sign_q <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= rs1;
            op_b   <= rs2;
            sign_q <= is_signed;
            idx    <= TOP_IDX;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            state  <= CMP;
          end
        end
        CMP: begin
          if (slice_a != slice_b) begin
            lt    <= (slice_a < slice_b);
            gt    <= (slice_a > slice_b);
            state <= DONE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_comparator_param.sv
// Directed and randomised checks of seq_comparator_param at (32,8), (64,16), (32,32) and (32,1);
// expected flags and latencies are hand-computed or come from a small $signed/$unsigned model.
module tb_seq_comparator_param;

  logic        clk;
  logic        rst_n;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        is_signed;
  logic [3:0]  in_valid_v;
  logic [3:0]  out_ready_v;
  logic [3:0]  in_ready_v;
  logic [3:0]  out_valid_v;
  logic [3:0]  lt_v;
  logic [3:0]  eq_v;
  logic [3:0]  gt_v;

  int num_compared;
  int num_mismatched;

  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  seq_comparator_param #(.WIDTH(32), .CHUNK(8)) u_dut_32_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .rs1(rs1[31:0]), .rs2(rs2[31:0]), .is_signed(is_signed), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0])
  );

  seq_comparator_param #(.WIDTH(64), .CHUNK(16)) u_dut_64_16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .rs1(rs1), .rs2(rs2), .is_signed(is_signed), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1])
  );

  seq_comparator_param #(.WIDTH(32), .CHUNK(32)) u_dut_32_32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .rs1(rs1[31:0]), .rs2(rs2[31:0]), .is_signed(is_signed), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .gt(gt_v[2])
  );

  seq_comparator_param #(.WIDTH(32), .CHUNK(1)) u_dut_32_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .rs1(rs1[31:0]), .rs2(rs2[31:0]), .is_signed(is_signed), .out_valid(out_valid_v[3]),
    .out_ready(out_ready_v[3]), .lt(lt_v[3]), .eq(eq_v[3]), .gt(gt_v[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [2:0] flagsOf(input int d);
    return {lt_v[d], eq_v[d], gt_v[d]};
  endfunction

  function automatic logic [63:0] widthMask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference ordering straight from SystemVerilog signed/unsigned comparison.
  function automatic logic [2:0] modelFlags(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic sgn);
    logic [63:0] m;
    logic [63:0] ax;
    logic [63:0] bx;
    m  = widthMask(w);
    ax = a & m;
    bx = b & m;
    if (sgn) begin
      if (a[w-1]) ax = ax | ~m;
      if (b[w-1]) bx = bx | ~m;
      if ($signed(ax) < $signed(bx)) return F_LT;
      if ($signed(ax) > $signed(bx)) return F_GT;
      return F_EQ;
    end
    if (ax < bx) return F_LT;
    if (ax > bx) return F_GT;
    return F_EQ;
  endfunction

  function automatic int modelLatency(input int w, input int c, input logic [63:0] a, input logic [63:0] b);
    int          ns;
    logic [63:0] cm;
    ns = w / c;
    cm = widthMask(c);
    for (int s = ns - 1; s >= 0; s--) begin
      if (((a >> (s * c)) & cm) != ((b >> (s * c)) & cm)) return ns - s;
    end
    return ns;
  endfunction

  // One full transaction on DUT d; optionally offers a second operand set while the result is stalled.
  task automatic applyStimulus(input int d, input logic [63:0] a, input logic [63:0] b, input logic sgn,
                               input logic [2:0] exp_flags, input int exp_lat, input int stall,
                               input logic pend);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready_v[d] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      checkOutput("in_ready_timeout", 64'(in_ready_v[d]), 64'd1);
      return;
    end
    rs1 = a;
    rs2 = b;
    is_signed = sgn;
    in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
    is_signed = ~sgn;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid_v[d] && lat < 100);
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("flags", 64'(flagsOf(d)), 64'(exp_flags));
    if (pend) begin
      rs1 = 64'h10;
      rs2 = 64'h0F;
      is_signed = 1'b0;
      in_valid_v[d] = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", 64'(out_valid_v[d]), 64'd1);
      checkOutput("hold_flags", 64'(flagsOf(d)), 64'(exp_flags));
      checkOutput("hold_in_ready", 64'(in_ready_v[d]), 64'd0);
    end
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    in_valid_v[d] = 1'b0;
    checkOutput("release_out_valid", 64'(out_valid_v[d]), 64'd0);
    checkOutput("release_in_ready", 64'(in_ready_v[d]), 64'd1);
    checkOutput("release_flags", 64'(flagsOf(d)), 64'(exp_flags));
  endtask

  // Async reset asserted mid-cycle after wait_edges edges of a 5-vs-7 op on the 32/8 instance.
  task automatic resetDuringOp(input int wait_edges);
    rs1 = 64'h5;
    rs2 = 64'h7;
    is_signed = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (wait_edges) @(posedge clk);
    #1;
    checkOutput("pre_reset_flags", 64'(flagsOf(0)), (wait_edges >= 4) ? 64'(F_LT) : 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid_v[0]), 64'd0);
    checkOutput("reset_flags", 64'(flagsOf(0)), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready_v[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic runSweep(input int d, input int w, input int c, input int n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] low;
    logic        sgn;
    int          pos;
    int          mode;
    for (int i = 0; i < n; i++) begin
      a    = {$urandom, $urandom};
      pos  = $urandom_range(0, w - 1);
      mode = $urandom_range(0, 2);
      sgn  = 1'($urandom_range(0, 1));
      low  = (64'd1 << pos) - 64'd1;
      if (mode == 0)      b = {$urandom, $urandom};
      else if (mode == 1) b = a;
      else                b = ((a & ~low) ^ (64'd1 << pos)) | ({$urandom, $urandom} & low);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      applyStimulus(d, a, b, sgn, modelFlags(w, a, b, sgn), modelLatency(w, c, a, b),
                    $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    rst_n       = 1'b0;
    rs1         = '0;
    rs2         = '0;
    is_signed   = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    #12;
    checkOutput("rst_out_valid", 64'(out_valid_v), 64'd0);
    checkOutput("rst_flags_32_8", 64'(flagsOf(0)), 64'd0);
    checkOutput("rst_flags_32_1", 64'(flagsOf(3)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 64'(in_ready_v), 64'hF);

    // 32-bit operands, 8-bit slices
    applyStimulus(0, 64'h5,         64'h7,         1'b0, F_LT, 4, 0, 1'b0);
    applyStimulus(0, 64'hFFFF_FFFF, 64'h1,         1'b1, F_LT, 1, 0, 1'b0);
    applyStimulus(0, 64'hFFFF_FFFF, 64'h1,         1'b0, F_GT, 1, 0, 1'b0);
    applyStimulus(0, 64'h8000_0000, 64'h8000_0000, 1'b1, F_EQ, 4, 0, 1'b0);
    applyStimulus(0, 64'h8000_0000, 64'h8000_0000, 1'b0, F_EQ, 4, 0, 1'b0);
    applyStimulus(0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, F_LT, 1, 0, 1'b0);
    applyStimulus(0, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, F_GT, 1, 0, 1'b0);
    applyStimulus(0, 64'h1234_5678, 64'h1234_5600, 1'b0, F_GT, 4, 5, 1'b1);
    applyStimulus(0, 64'h10,        64'h0F,        1'b0, F_GT, 4, 0, 1'b0);

    resetDuringOp(2);
    resetDuringOp(6);
    applyStimulus(0, 64'h10,        64'h0F,        1'b0, F_GT, 4, 0, 1'b0);

    // 64/16, 32/32 and 32/1 corner cases
    applyStimulus(1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, F_LT, 1, 0, 1'b0);
    applyStimulus(1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, F_GT, 1, 0, 1'b0);
    applyStimulus(1, 64'h5,         64'h7,         1'b0, F_LT, 4, 1, 1'b0);
    applyStimulus(2, 64'h5,         64'h7,         1'b0, F_LT, 1, 0, 1'b0);
    applyStimulus(2, 64'hFFFF_FFFF, 64'h1,         1'b1, F_LT, 1, 0, 1'b0);
    applyStimulus(2, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1, F_EQ, 1, 0, 1'b0);
    applyStimulus(3, 64'h5,         64'h7,         1'b0, F_LT, 31, 0, 1'b0);
    applyStimulus(3, 64'hFFFF_FFFF, 64'h1,         1'b1, F_LT, 1, 0, 1'b0);
    applyStimulus(3, 64'h8000_0000, 64'h8000_0000, 1'b1, F_EQ, 32, 0, 1'b0);

    runSweep(0, 32, 8, 300);
    runSweep(1, 64, 16, 300);
    runSweep(2, 32, 32, 300);
    runSweep(3, 32, 1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
